// File: rtl/rdata_fifo_s.sv
// rdata_fifo_s: R-channel beat buffer between a slave R output and the R demux.
// Holds up to DEPTH beats in arrival order with valid/ready handshakes on both
// sides, and reports both the beat count and the number of held last beats.
module rdata_fifo_s #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic [3:0]    rid_s,
   input  logic [31:0]   rdata_s,
   input  logic          rlast_s,
   input  logic [1:0]    rresp_s,
   input  logic          rvalid_s,
   output logic          rready_s,
   output logic [3:0]    rid_d,
   output logic [31:0]   rdata_d,
   output logic          rlast_d,
   output logic [1:0]    rresp_d,
   output logic          rvalid_d,
   input  logic          rready_d,
   output logic [AW:0]   count,
   output logic [AW:0]   last_cnt
);

   localparam logic [AW:0] DepthVal = DEPTH[AW:0];

   // Entry layout: {rid[38:35], rdata[34:3], rlast[2], rresp[1:0]}
   logic [38:0] r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [AW:0] r_lastCnt;

   logic [AW:0] w_count;
   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic [38:0] w_head;

   // Occupancy comes straight from the pointer difference; the wrap bit keeps
   // full and empty distinguishable when the indices coincide.
   always_comb begin
      w_count  = r_wptr - r_rptr;
      w_empty  = (w_count == '0);
      w_full   = (w_count == DepthVal);
      rready_s = areset & ~w_full;
      rvalid_d = ~w_empty;
      w_push   = rvalid_s & rready_s;
      w_pop    = rvalid_d & rready_d;
      w_head   = r_mem[r_rptr[AW-1:0]];
      rid_d    = w_head[38:35];
      rdata_d  = w_head[34:3];
      rlast_d  = w_head[2];
      rresp_d  = w_head[1:0];
      count    = w_count;
      last_cnt = r_lastCnt;
   end

   // Beat storage; cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= {rid_s, rdata_s, rlast_s, rresp_s};
      end
   end

   // Write and read pointers advance independently on push and pop.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Count of held last beats: a last in and a last out cancel each other.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         r_lastCnt <= '0;
      end else begin
         case ({w_push & rlast_s, w_pop & rlast_d})
            2'b10:   r_lastCnt <= r_lastCnt + 1'b1;
            2'b01:   r_lastCnt <= r_lastCnt - 1'b1;
            default: r_lastCnt <= r_lastCnt;
         endcase
      end
   end

endmodule

// File: tb/tb_rdata_fifo_s.sv
// tb_rdata_fifo_s: randomized and directed bench for rdata_fifo_s, checked
// against a queue model of the buffer contents.
module tb_rdata_fifo_s;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          aclk;
   logic          areset;
   logic [3:0]    rid_s;
   logic [31:0]   rdata_s;
   logic          rlast_s;
   logic [1:0]    rresp_s;
   logic          rvalid_s;
   logic          rready_s;
   logic [3:0]    rid_d;
   logic [31:0]   rdata_d;
   logic          rlast_d;
   logic [1:0]    rresp_d;
   logic          rvalid_d;
   logic          rready_d;
   logic [AW:0]   count;
   logic [AW:0]   last_cnt;

   int testsRun;
   int testsFailed;

   // Model: queue of beats {rid, rdata, rlast, rresp}, oldest at the front
   logic [38:0] modelQ [$];

   rdata_fifo_s #(.DEPTH(DEPTH), .AW(AW)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .rid_s    (rid_s),
      .rdata_s  (rdata_s),
      .rlast_s  (rlast_s),
      .rresp_s  (rresp_s),
      .rvalid_s (rvalid_s),
      .rready_s (rready_s),
      .rid_d    (rid_d),
      .rdata_d  (rdata_d),
      .rlast_d  (rlast_d),
      .rresp_d  (rresp_d),
      .rvalid_d (rvalid_d),
      .rready_d (rready_d),
      .count    (count),
      .last_cnt (last_cnt)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int modelLastCount();
      int n = 0;
      foreach (modelQ[i]) begin
         if (modelQ[i][2]) n++;
      end
      return n;
   endfunction

   // Compare every visible output with what the model says the buffer holds
   task automatic checkModel(input string tag);
      checkOutput({tag, ".rready_s"}, 64'(rready_s), 64'(modelQ.size() < DEPTH));
      checkOutput({tag, ".rvalid_d"}, 64'(rvalid_d), 64'(modelQ.size() > 0));
      checkOutput({tag, ".count"}, 64'(count), 64'(modelQ.size()));
      checkOutput({tag, ".last_cnt"}, 64'(last_cnt), 64'(modelLastCount()));
      if (modelQ.size() > 0) begin
         checkOutput({tag, ".head"}, 64'({rid_d, rdata_d, rlast_d, rresp_d}), 64'(modelQ[0]));
      end
   endtask

   // Drive one cycle of inputs, check pre-edge outputs, clock, update model
   task automatic applyStimulus(input string tag, input logic vs, input logic [3:0] id,
                                input logic [31:0] data, input logic last, input logic [1:0] resp,
                                input logic rd, output logic accepted);
      logic doPush;
      logic doPop;
      rvalid_s = vs;
      rid_s    = id;
      rdata_s  = data;
      rlast_s  = last;
      rresp_s  = resp;
      rready_d = rd;
      #1;
      checkModel(tag);
      doPush = vs && (modelQ.size() < DEPTH);
      doPop  = rd && (modelQ.size() > 0);
      @(posedge aclk);
      #1;
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back({id, data, last, resp});
      accepted = doPush;
   endtask

   // Present a beat and hold it until the buffer takes it (bounded wait)
   task automatic pushBeat(input string tag, input logic [3:0] id, input logic [31:0] data,
                           input logic last, input logic rd);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         applyStimulus(tag, 1'b1, id, data, last, 2'd0, rd, acc);
         tries++;
      end
      if (!acc) checkOutput({tag, ".timeout"}, 64'(0), 64'(1));
   endtask

   initial begin
      logic acc;
      int   drainCnt;
      testsRun    = 0;
      testsFailed = 0;
      areset   = 1'b0;
      rvalid_s = 1'b1;
      rid_s    = 4'hF;
      rdata_s  = 32'hFFFF_FFFF;
      rlast_s  = 1'b1;
      rresp_s  = 2'b11;
      rready_d = 1'b1;

      // Reset held with the slave asserting valid
      repeat (3) @(posedge aclk);
      #2;
      checkOutput("rst.rready_s", 64'(rready_s), 64'(0));
      checkOutput("rst.rvalid_d", 64'(rvalid_d), 64'(0));
      checkOutput("rst.count", 64'(count), 64'(0));
      checkOutput("rst.last_cnt", 64'(last_cnt), 64'(0));
      checkOutput("rst.data", 64'({rid_d, rdata_d, rlast_d, rresp_d}), 64'(0));
      rvalid_s = 1'b0;
      @(negedge aclk);
      areset = 1'b1;
      #1;
      checkOutput("rel.rready_s", 64'(rready_s), 64'(1));
      @(posedge aclk);
      #1;

      // Single beat
      applyStimulus("single.push", 1'b1, 4'h2, 32'hDEADBEEF, 1'b1, 2'd0, 1'b0, acc);
      checkOutput("single.valid", 64'(rvalid_d), 64'(1));
      checkOutput("single.data", 64'(rdata_d), 64'(32'hDEADBEEF));
      checkOutput("single.cnt", 64'(count), 64'(1));
      checkOutput("single.lcnt", 64'(last_cnt), 64'(1));
      applyStimulus("single.pop", 1'b0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
      checkOutput("single.empty", 64'(rvalid_d), 64'(0));
      checkOutput("single.cnt0", 64'(count), 64'(0));
      checkOutput("single.lcnt0", 64'(last_cnt), 64'(0));

      // Fill to full with the demux stalled, then hold a fifth beat
      for (int i = 1; i <= 4; i++) begin
         pushBeat("fill", 4'h1, 32'(i), 1'b0, 1'b0);
      end
      checkOutput("full.rready_s", 64'(rready_s), 64'(0));
      checkOutput("full.count", 64'(count), 64'(4));
      applyStimulus("full.hold", 1'b1, 4'h1, 32'd5, 1'b0, 2'd0, 1'b0, acc);
      checkOutput("full.notTaken", 64'(acc), 64'(0));
      checkOutput("full.head1", 64'(rdata_d), 64'(1));
      applyStimulus("full.pop", 1'b1, 4'h1, 32'd5, 1'b0, 2'd0, 1'b1, acc);
      checkOutput("full.noPass", 64'(acc), 64'(0));
      checkOutput("full.readyAgain", 64'(rready_s), 64'(1));
      pushBeat("full.take5", 4'h1, 32'd5, 1'b0, 1'b0);
      for (int i = 2; i <= 5; i++) begin
         checkOutput("drain.order", 64'(rdata_d), 64'(i));
         applyStimulus("drain", 1'b0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
      end
      checkOutput("drain.empty", 64'(rvalid_d), 64'(0));

      // Back-to-back streaming: occupancy never exceeds one beat
      for (int i = 0; i < 20; i++) begin
         applyStimulus("stream", 1'b1, 4'(i), 32'h100 + 32'(i), 1'(i % 3 == 2), 2'(i), 1'b1, acc);
         checkOutput("stream.cntLe1", 64'(count <= 1), 64'(1));
      end
      // Alternating demux ready across pointer wrap
      for (int i = 0; i < 20; i++) begin
         applyStimulus("alt", 1'b1, 4'(i), 32'h200 + 32'(i), 1'(i % 2), 2'(i), 1'(i % 2), acc);
      end
      drainCnt = 0;
      while (modelQ.size() > 0 && drainCnt < 20) begin
         applyStimulus("alt.drain", 1'b0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
         drainCnt++;
      end
      checkModel("alt.end");

      // Two 3-beat bursts into a 4-deep buffer: back-pressure after beat 4
      for (int i = 1; i <= 4; i++) begin
         pushBeat("burst", (i <= 3) ? 4'h0 : 4'h2, 32'h300 + 32'(i), 1'(i == 3), 1'b0);
      end
      checkOutput("burst.count", 64'(count), 64'(4));
      checkOutput("burst.lcnt", 64'(last_cnt), 64'(1));
      checkOutput("burst.bp", 64'(rready_s), 64'(0));
      drainCnt = 0;
      while (modelQ.size() > 1 && drainCnt < 10) begin
         applyStimulus("burst.drain", 1'b0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
         drainCnt++;
      end
      // Only the head beat (not last) remains; now stack a last beat behind it
      pushBeat("lastA", 4'h2, 32'h401, 1'b1, 1'b1);
      checkOutput("lastA.lcnt", 64'(last_cnt), 64'(1));
      checkOutput("lastA.headLast", 64'(rlast_d), 64'(1));
      // Push a last beat while popping a last beat
      applyStimulus("lastSwap", 1'b1, 4'h2, 32'h402, 1'b1, 2'd0, 1'b1, acc);
      checkOutput("lastSwap.lcnt", 64'(last_cnt), 64'(1));
      checkOutput("lastSwap.count", 64'(count), 64'(1));

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 32'($urandom),
                       1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0), acc);
      end

      // Mid-cycle reset with three beats held
      drainCnt = 0;
      while (modelQ.size() > 0 && drainCnt < 10) begin
         applyStimulus("pre.drain", 1'b0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
         drainCnt++;
      end
      for (int i = 0; i < 3; i++) begin
         pushBeat("mid", 4'h3, 32'h500 + 32'(i), 1'b1, 1'b0);
      end
      rvalid_s = 1'b0;
      checkOutput("mid.count3", 64'(count), 64'(3));
      #2;
      areset = 1'b0;
      #1;
      modelQ.delete();
      checkOutput("mid.rvalid_d", 64'(rvalid_d), 64'(0));
      checkOutput("mid.count", 64'(count), 64'(0));
      checkOutput("mid.last_cnt", 64'(last_cnt), 64'(0));
      checkOutput("mid.rready_s", 64'(rready_s), 64'(0));
      @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      checkModel("mid.after");
      applyStimulus("mid.post", 1'b1, 4'hA, 32'h600, 1'b1, 2'd1, 1'b0, acc);
      checkModel("mid.post2");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/rdata_fifo_s.md
# rdata_fifo_s

Read-data (R channel) buffer between a slave's R output and the 1-to-2 R demux that routes beats to master 1 or master 2 by rid[1]. It stores up to DEPTH beats and presents them in order with a standard valid/ready handshake on both sides. This decouples slave back-pressure from master rready. It also reports how many complete bursts (beats with rlast=1) are held.

## Interface
- DEPTH, 4, number of beat entries; power of two, ≥2
- AW, 2, log2(DEPTH)
- aclk  in  1  clock; all state updates on rising edge
- areset  in  1  asynchronous, active-low reset
- rid_s  in  4  slave beat ID
- rdata_s  in  32  slave beat data
- rlast_s  in  1  slave last-beat flag
- rresp_s  in  2  slave response
- rvalid_s  in  1  slave beat valid
- rready_s  out  1  buffer can accept a beat
- rid_d  out  4  head beat ID, to demux
- rdata_d  out  32  head beat data
- rlast_d  out  1  head last-beat flag
- rresp_d  out  2  head response
- rvalid_d  out  1  head beat valid
- rready_d  in  1  demux accepts head beat
- count  out  AW+1  beats stored, 0..DEPTH
- last_cnt  out  AW+1  stored beats with rlast=1, 0..DEPTH

## Operation
- Storage: DEPTH × 39-bit entries {rid, rdata, rlast, rresp}.
- Pointers: wptr and rptr, each AW+1 bits. Index = low AW bits. The MSB is the wrap bit.
- count = wptr − rptr, modulo 2^(AW+1).
- empty = (count==0). full = (count==DEPTH).
- push = rvalid_s & rready_s. On push, write the entry at wptr[AW-1:0] and increment wptr.
- pop = rvalid_d & rready_d. On pop, increment rptr.
- rready_s = areset & ~full. It is forced 0 while reset is asserted.
- rvalid_d = ~empty.
- rid_d, rdata_d, rlast_d and rresp_d are combinational reads of the entry at rptr[AW-1:0].
- While rvalid_d=1 and rready_d=0, the head outputs hold stable. This satisfies AXI.
- No bypass path: a beat pushed into an empty buffer appears at the output the next cycle.
- Order is strictly FIFO. No reordering by ID. Routing by rid[1] is the demux's job.
- last_cnt update each cycle:
  - +1 on a push with rlast_s=1.
  - −1 on a pop with rlast_d=1.
  - Unchanged if both or neither occur.
- Push and pop in the same cycle: both take effect; count is unchanged.
- Full: rready_s=0, so no push. A pop while full makes rready_s=1 on the next cycle. There is no same-cycle pass-through.
- Empty: rvalid_d=0, so no pop. rready_d is ignored.
- Wrap-around: pointers roll from 2^(AW+1)−1 to 0. count remains correct across the wrap.
- rvalid_s with rready_s=0: beat not taken; the slave must hold it.

## Timing
- Reset (areset low, asynchronous):
  - wptr=0, rptr=0, last_cnt=0, all storage entries=0.
  - Hence rvalid_d=0, count=0, rid_d=0, rdata_d=0, rlast_d=0, rresp_d=0, rready_s=0.
- First cycle after release: rready_s=1.
- Reset mid-operation: all buffered beats are discarded immediately. Outputs take reset values asynchronously.
- Latency: a push at edge N makes rvalid_d=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle sustained when both sides are ready.
- count and last_cnt are registered. Both reflect the state after the most recent edge.
- No combinational path from rready_d to rready_s, or from rvalid_s to rvalid_d.

## Test plan
- Reset: hold areset=0 with rvalid_s=1. Required: rready_s=0, rvalid_d=0, count=0, all data outputs 0. After release, rready_s=1 on the first cycle.
- Single beat: push rid=4'h2, rdata=32'hDEADBEEF, rlast=1, rresp=0.
  - Next cycle: rvalid_d=1 with the same fields; count=1, last_cnt=1.
  - Pop with rready_d=1: rvalid_d=0, count=0, last_cnt=0.
- Fill/full (DEPTH=4), with rready_d=0:
  - Push beats with rdata 1,2,3,4; then rready_s=0 and count=4.
  - A fifth beat (rdata=5) is held by the slave.
  - One pop gives rdata_d=1; rready_s=1 next cycle; then 5 is accepted.
  - Drain order must be 2,3,4,5.
- Streaming with wrap: 20 back-to-back beats with rvalid_s=1 and rready_d=1. Output data must match input order, with count never above 1.
  - Then toggle rready_d on alternate cycles: order is preserved across pointer wrap, and no beat is dropped or duplicated.
- Bursts: push two 3-beat bursts (rid 0 then rid 2, rlast on beats 3 and 6) with rready_d=0. Required: last_cnt=2, count=6.
  - This needs DEPTH=8; with DEPTH=4, expect count=4 and last_cnt=1 with back-pressure instead.
  - Simultaneous push of a last beat and pop of a last beat leaves last_cnt unchanged.
- Reset mid-burst: with 3 beats held, assert areset=0 mid-cycle. Outputs clear immediately: rvalid_d=0, count=0, last_cnt=0. After release the buffer is empty.
